// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: blank codes, hex decode table, digit index type.
// The LEADING_ZERO_BLANK_EN macro is consumed by the top level, not by this package.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] ANODES_OFF = 4'hF;
    localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit common-anode driver with frame-latched display word.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] NUM_IN,
    input  logic [3:0]  DP_IN,
    input  logic        ENABLE,
    output logic [3:0]  SEG_SELECT,
    output logic [7:0]  LED_OUT,
    output logic        FRAME_TICK
);

    localparam int CNT_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [15:0]      shadow_num_q, shadow_num_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic             load_pending_q, load_pending_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       seg_sel_q, seg_sel_d;
    logic [7:0]       led_q, led_d;

    logic             tick;
    logic             latch;
    logic [3:0]       cur_nibble;
    logic             cur_dp;
    logic [6:0]       cur_seg;
    logic             blank;

    assign tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign latch = (tick && idx_q == 2'd3) || load_pending_q;

    always_comb begin
        cnt_d          = tick ? '0 : cnt_q + 1'b1;
        idx_d          = tick ? idx_q + 2'd1 : idx_q;
        shadow_num_d   = latch ? NUM_IN : shadow_num_q;
        shadow_dp_d    = latch ? DP_IN  : shadow_dp_q;
        load_pending_d = 1'b0;
        frame_tick_d   = latch;
    end

    assign cur_nibble = shadow_num_q[{idx_q, 2'b00} +: 4];
    assign cur_dp     = shadow_dp_q[idx_q];

    seg_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg_n  (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = (shadow_num_q[15:12] == 4'h0);
            2'd2:    blank = (shadow_num_q[15:8]  == 8'h00);
            2'd1:    blank = (shadow_num_q[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_sel_d = ~(4'b0001 << idx_q);
        led_d     = {~cur_dp, cur_seg};
        if (blank) begin
            if (cur_dp) begin
                led_d = SEG_DP_ONLY;
            end else begin
                seg_sel_d = ANODES_OFF;
                led_d     = SEG_BLANK;
            end
        end
        // Shadow is still stale during the very first post-reset cycle.
        if (!ENABLE || load_pending_q) begin
            seg_sel_d = ANODES_OFF;
            led_d     = SEG_BLANK;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_num_q   <= '0;
            shadow_dp_q    <= '0;
            load_pending_q <= 1'b1;
            frame_tick_q   <= 1'b0;
            seg_sel_q      <= ANODES_OFF;
            led_q          <= SEG_BLANK;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_num_q   <= shadow_num_d;
            shadow_dp_q    <= shadow_dp_d;
            load_pending_q <= load_pending_d;
            frame_tick_q   <= frame_tick_d;
            seg_sel_q      <= seg_sel_d;
            led_q          <= led_d;
        end
    end

    assign SEG_SELECT = seg_sel_q;
    assign LED_OUT    = led_q;
    assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with REFRESH_DIV=4; edges counted from reset release.
module tb_seven_segment_scanner;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] NUM_IN;
    logic [3:0]  DP_IN;
    logic        ENABLE;
    logic [3:0]  SEG_SELECT;
    logic [7:0]  LED_OUT;
    logic        FRAME_TICK;

    int n_chk  = 0;
    int n_pass = 0;
    int e      = 0;

    seven_segment_scanner #(.REFRESH_DIV(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .NUM_IN     (NUM_IN),
        .DP_IN      (DP_IN),
        .ENABLE     (ENABLE),
        .SEG_SELECT (SEG_SELECT),
        .LED_OUT    (LED_OUT),
        .FRAME_TICK (FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel, input logic [7:0] led);
        chk({tag, ".sel"}, {4'h0, SEG_SELECT}, {4'h0, sel});
        chk({tag, ".led"}, LED_OUT, led);
    endtask

    // Advance to just after rising edge number `target`, sampled on the falling edge.
    task automatic go(input int target);
        while (e < target) begin
            @(posedge CLK);
            e++;
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET  = 1'b0;
        NUM_IN = 16'h12AF;
        DP_IN  = 4'h0;
        ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        chk_out("rst", 4'hF, 8'hFF);
        chk("rst.tick", {7'h0, FRAME_TICK}, 8'h00);

        RESET = 1'b1;
        e = 0;
        go(1);
        chk("first.tick", {7'h0, FRAME_TICK}, 8'h01);
        chk_out("first", 4'hF, 8'hFF);
        go(2);
        chk_out("d0", 4'hE, 8'h8E);
        chk("d0.tick", {7'h0, FRAME_TICK}, 8'h00);
        go(5);  chk_out("d1", 4'hD, 8'h88);
        go(9);  chk_out("d2", 4'hB, 8'hA4);
        go(13); chk_out("d3", 4'h7, 8'hF9);
        go(16); chk("wrap.tick", {7'h0, FRAME_TICK}, 8'h01);
        go(17); chk_out("d0b", 4'hE, 8'h8E);

        // Mid-frame word change must wait for the next frame latch.
        go(22); NUM_IN = 16'h0000;
        go(25); chk_out("mid.d2", 4'hB, 8'hA4);
        go(29); chk_out("mid.d3", 4'h7, 8'hF9);
        go(31); chk("mid.notick", {7'h0, FRAME_TICK}, 8'h00);
        go(32); chk("mid.tick", {7'h0, FRAME_TICK}, 8'h01);
        go(33); chk_out("zero.d0", 4'hE, 8'hC0);
        go(34); chk("zero.tickoff", {7'h0, FRAME_TICK}, 8'h00);

        NUM_IN = 16'h0005;
        DP_IN  = 4'b0001;
        go(49); chk_out("five.d0", 4'hE, 8'h12);
`ifdef LEADING_ZERO_BLANK_EN
        go(53); chk_out("five.d1", 4'hF, 8'hFF);
        go(57); chk_out("five.d2", 4'hF, 8'hFF);
        go(61); chk_out("five.d3", 4'hF, 8'hFF);
`else
        go(53); chk_out("five.d1", 4'hD, 8'hC0);
        go(57); chk_out("five.d2", 4'hB, 8'hC0);
        go(61); chk_out("five.d3", 4'h7, 8'hC0);
`endif

        // Disable mid-slot; scanning and frame latching keep running underneath.
        go(62); ENABLE = 1'b0;
        go(63); chk_out("dis", 4'hF, 8'hFF);
        go(64); chk("dis.tick", {7'h0, FRAME_TICK}, 8'h01);
        chk_out("dis2", 4'hF, 8'hFF);
        go(66); ENABLE = 1'b1;
        go(67); chk_out("reen.d0", 4'hE, 8'h12);
`ifdef LEADING_ZERO_BLANK_EN
        go(69); chk_out("reen.d1", 4'hF, 8'hFF);
`else
        go(69); chk_out("reen.d1", 4'hD, 8'hC0);
`endif

        // Async reset between clock edges.
        go(70);
        #2 RESET = 1'b0;
        #1 chk_out("arst", 4'hF, 8'hFF);
        chk("arst.tick", {7'h0, FRAME_TICK}, 8'h00);
        NUM_IN = 16'h12AF;
        DP_IN  = 4'h0;
        @(negedge CLK);
        RESET = 1'b1;
        e = 0;
        go(1); chk_out("rel1", 4'hF, 8'hFF);
        chk("rel1.tick", {7'h0, FRAME_TICK}, 8'h01);
        go(2); chk_out("rel.d0", 4'hE, 8'h8E);
        go(5); chk_out("rel.d1", 4'hD, 8'h88);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
